set_inf_zero_bits: RTL and testbench
====================================

# set_inf_zero_bits

Classifies a decoded posit's special value from its sign bit and the "all remaining bits zero" flag. The 2-bit code distinguishes ordinary values, zero and infinity (NaR). The block sits in the decoder front end, after the all-zeros detector and before the regime/exponent/fraction extraction. It provides an immediate combinational code, a registered copy with a valid flag, and optional saturating statistics counters.

## Interface
Parameters:
- CNT_W, default 16: width of each statistics counter, legal range 1..32.

Ports:
- clk  in  1  — system clock; all registers use the rising edge.
- rst  in  1  — reset, asynchronous and active-high.
- in_valid  in  1  — qualifies signbit/allzeros for the registered path and the counters.
- signbit  in  1  — MSB of the posit word.
- allzeros  in  1  — 1 when every bit below the sign bit is 0.
- stats_clr  in  1  — synchronous clear of both counters.
- result  out  2  — combinational special-value code.
- result_q  out  2  — registered special-value code.
- out_valid  out  1  — registered in_valid.
- zero_count  out  CNT_W  — number of valid zero inputs; saturating.
- inf_count  out  CNT_W  — number of valid infinity inputs; saturating.

## Operation
- Code encoding:
  - 2'b00 NORMAL: allzeros=0, either sign.
  - 2'b01 ZERO: signbit=0, allzeros=1.
  - 2'b10 INF/NaR: signbit=1, allzeros=1.
  - 2'b11 is never produced.
- Logic: result[1] = signbit & allzeros; result[0] = ~signbit & allzeros.
- result does not depend on in_valid, clk or rst.
- Registered path:
  - result_q loads result on every cycle where in_valid=1.
  - result_q holds its value when in_valid=0.
  - out_valid <= in_valid on every cycle.
- Counters (see Configuration):
  - zero_count increments on a cycle with in_valid=1 and result=ZERO.
  - inf_count increments on a cycle with in_valid=1 and result=INF.
  - Each counter stops at all-ones (saturates) and does not wrap.
  - stats_clr=1 sets both counters to 0 on the next edge. It overrides an increment in the same cycle.

## Timing
- result: zero cycles of latency, purely combinational.
- result_q and out_valid: 1-cycle latency.
- Counters: update on the edge after the qualifying input cycle.
- Reset values: result_q=2'b00, out_valid=0, zero_count=0, inf_count=0.
- Reset asserted mid-stream clears the registered outputs at once, without waiting for a clock edge. The combinational result keeps following its inputs during reset.
- The first valid input after reset release is reflected one cycle later.
- There is no handshake or backpressure. Every valid cycle is accepted.

## Configuration
- SET_INF_ZERO_BITS_STATS_EN defined:
  - Both counters and the stats_clr logic are built.
- Macro absent:
  - zero_count and inf_count are tied to 0.
  - stats_clr is ignored.
  - No counter flops are generated.
  - The port list is identical in both builds.

## Structure
- Shared package posit_special_pkg holds:
  - typedef enum logic [1:0] special_t {SPC_NORMAL=2'b00, SPC_ZERO=2'b01, SPC_INF=2'b10}.
  - The CNT_W default constant.
- One sub-module, sat_counter (parameter W; inputs inc and clr; output count). It is instantiated twice, under the macro.

## Test plan
- Truth table: sign/allzeros = 0/0, 0/1, 1/0, 1/1 applied in turn → result = 0, 1, 0, 2 combinationally. With in_valid=1, result_q shows the same codes one cycle later.
- Hold: in_valid=1 with 1/1, then in_valid=0 with 0/1 → result_q stays 2 and out_valid drops to 0.
- Reset: drive result_q=2, then pulse rst between clock edges → result_q=0 and out_valid=0 immediately.
- Counters (macro on): 3 valid zeros, 2 valid infs and 1 invalid zero → zero_count=3, inf_count=2.
- Saturation and clear: CNT_W=2 with 5 valid zeros → zero_count=3. stats_clr asserted together with a valid zero → zero_count=0.
- Macro off: the same stimulus as the counter test → both counts stay 0, and result/result_q behave unchanged.

Source files
------------

// File: rtl/posit_special_pkg.sv
// Shared definitions for the posit special-value classifier: the 2-bit
// special-value code, the default statistics counter width and the
// classification function used by the decoder front end.
package posit_special_pkg;

   // Special-value code; 2'b11 is never produced by the classifier.
   typedef enum logic [1:0] {
      SPC_NORMAL = 2'b00,
      SPC_ZERO   = 2'b01,
      SPC_INF    = 2'b10
   } special_t;

   // Default width of each statistics counter (legal range 1..32).
   localparam int CNT_W_DEFAULT = 16;

   // A posit whose bits below the sign are all zero is either zero
   // (sign clear) or NaR (sign set); anything else is an ordinary value.
   function automatic special_t classify(input logic sign, input logic all_zero);
      logic [1:0] code;
      code[1] = sign & all_zero;
      code[0] = ~sign & all_zero;
      return special_t'(code);
   endfunction

endpackage

// File: rtl/set_inf_zero_bits_sat_counter.sv
// Saturating up-counter with synchronous clear. Counts 'inc' pulses,
// sticks at all-ones instead of wrapping, and clear wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic at_max;

   // Flag the saturation point so an increment there is dropped.
   always_comb begin
      at_max = &count;
   end

   // Counter register: clear first, then increment unless saturated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/set_inf_zero_bits.sv
// Posit special-value classifier for the decoder front end.
// Produces a combinational code from the sign bit and the all-zeros flag,
// a registered copy qualified by in_valid, and optional saturating
// zero/NaR statistics counters built only when SET_INF_ZERO_BITS_STATS_EN
// is defined. The port list is the same in both builds.
module set_inf_zero_bits
   import posit_special_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             signbit,
   input  logic             allzeros,
   input  logic             stats_clr,
   output logic [1:0]       result,
   output logic [1:0]       result_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] zero_count,
   output logic [CNT_W-1:0] inf_count
);

   special_t code;
   special_t code_q;

   // Classify the current word; independent of valid, clock and reset.
   always_comb begin
      code   = classify(signbit, allzeros);
      result = code;
   end

   // Registered code: captured only on valid cycles, held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q <= SPC_NORMAL;
      end else if (in_valid) begin
         code_q <= code;
      end
   end

   // Valid flag follows in_valid with one cycle of delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
      end
   end

   assign result_q = code_q;

`ifdef SET_INF_ZERO_BITS_STATS_EN

   logic zero_inc;
   logic inf_inc;

   // Only accepted words contribute to the statistics.
   always_comb begin
      zero_inc = in_valid && (code == SPC_ZERO);
      inf_inc  = in_valid && (code == SPC_INF);
   end

   sat_counter #(
      .W(CNT_W)
   ) u_zero_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (zero_inc),
      .clr   (stats_clr),
      .count (zero_count)
   );

   sat_counter #(
      .W(CNT_W)
   ) u_inf_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inf_inc),
      .clr   (stats_clr),
      .count (inf_count)
   );

`else

   // Statistics disabled: counts read as zero and the clear is a no-op.
   logic unused_stats_clr;

   assign zero_count       = '0;
   assign inf_count        = '0;
   assign unused_stats_clr = stats_clr;

`endif

endmodule

// File: tb/tb_set_inf_zero_bits.sv
// Self-checking bench for set_inf_zero_bits. A behavioural model (lookup
// table for the code, plain integers for the counters) tracks the expected
// outputs; the DUT is built with 2-bit counters so saturation is reachable.
module tb_set_inf_zero_bits;

   localparam int TB_CNT_W = 2;
   localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

`ifdef SET_INF_ZERO_BITS_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                signbit;
   logic                allzeros;
   logic                stats_clr;
   logic [1:0]          result;
   logic [1:0]          result_q;
   logic                out_valid;
   logic [TB_CNT_W-1:0] zero_count;
   logic [TB_CNT_W-1:0] inf_count;

   int errors;
   int checks;

   logic [1:0] exp_q;
   logic       exp_valid;
   int         exp_zero;
   int         exp_inf;

   set_inf_zero_bits #(
      .CNT_W(TB_CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .signbit    (signbit),
      .allzeros   (allzeros),
      .stats_clr  (stats_clr),
      .result     (result),
      .result_q   (result_q),
      .out_valid  (out_valid),
      .zero_count (zero_count),
      .inf_count  (inf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference code straight from the encoding table.
   function automatic logic [1:0] ref_code(input logic s, input logic a);
      logic [1:0] table_val [4];
      table_val[0] = 2'd0;
      table_val[1] = 2'd1;
      table_val[2] = 2'd0;
      table_val[3] = 2'd2;
      return table_val[{s, a}];
   endfunction

   // Advance one clock edge, update the model from the inputs seen at the
   // edge, then step just past the edge for sampling.
   task automatic tick();
      logic [1:0] c;
      @(posedge clk);
      if (!rst) begin
         c = ref_code(signbit, allzeros);
         if (in_valid) exp_q = c;
         exp_valid = in_valid;
         if (STATS) begin
            if (stats_clr) begin
               exp_zero = 0;
               exp_inf  = 0;
            end else if (in_valid) begin
               if (c == 2'd1 && exp_zero < CNT_MAX) exp_zero = exp_zero + 1;
               if (c == 2'd2 && exp_inf < CNT_MAX) exp_inf = exp_inf + 1;
            end
         end
      end
      #1;
   endtask

   task automatic model_reset();
      exp_q     = 2'd0;
      exp_valid = 1'b0;
      exp_zero  = 0;
      exp_inf   = 0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      signbit   = 1'b1;
      allzeros  = 1'b1;
      stats_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (result_q !== 2'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_regs result_q=%0d out_valid=%0b expected 0/0", result_q, out_valid);
      end
      checks++;
      if (zero_count !== '0 || inf_count !== '0) begin
         errors++;
         $display("[TB] FAIL reset_counts zero=%0d inf=%0d expected 0/0", zero_count, inf_count);
      end
      checks++;
      if (result !== 2'd2) begin
         errors++;
         $display("[TB] FAIL reset_comb result=%0d expected 2", result);
      end
      in_valid = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic test_truth_table();
      logic [1:0] req [4];
      req[0] = 2'd0;
      req[1] = 2'd1;
      req[2] = 2'd0;
      req[3] = 2'd2;
      for (int i = 0; i < 4; i++) begin
         signbit  = i[1];
         allzeros = i[0];
         in_valid = 1'b1;
         #1;
         checks++;
         if (result !== req[i]) begin
            errors++;
            $display("[TB] FAIL truth_comb idx=%0d got=%0d expected=%0d", i, result, req[i]);
         end
         tick();
         checks++;
         if (result_q !== req[i] || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL truth_reg idx=%0d got=%0d/%0b expected=%0d/1", i, result_q, out_valid, req[i]);
         end
      end
   endtask

   task automatic test_hold();
      in_valid = 1'b1;
      signbit  = 1'b1;
      allzeros = 1'b1;
      tick();
      in_valid = 1'b0;
      signbit  = 1'b0;
      allzeros = 1'b1;
      #1;
      checks++;
      if (result !== 2'd1) begin
         errors++;
         $display("[TB] FAIL hold_comb result=%0d expected 1", result);
      end
      tick();
      checks++;
      if (result_q !== 2'd2 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_reg result_q=%0d out_valid=%0b expected 2/0", result_q, out_valid);
      end
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1;
      signbit  = 1'b1;
      allzeros = 1'b1;
      tick();
      checks++;
      if (result_q !== 2'd2) begin
         errors++;
         $display("[TB] FAIL areset_pre result_q=%0d expected 2", result_q);
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (result_q !== 2'd0 || out_valid !== 1'b0 || zero_count !== '0 || inf_count !== '0) begin
         errors++;
         $display("[TB] FAIL areset_now result_q=%0d out_valid=%0b zero=%0d inf=%0d expected 0", result_q, out_valid, zero_count, inf_count);
      end
      checks++;
      if (result !== 2'd2) begin
         errors++;
         $display("[TB] FAIL areset_comb result=%0d expected 2", result);
      end
      rst      = 1'b0;
      signbit  = 1'b0;
      allzeros = 1'b1;
      tick();
      checks++;
      if (result_q !== 2'd1 || out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL areset_first result_q=%0d out_valid=%0b expected 1/1", result_q, out_valid);
      end
   endtask

   task automatic test_counters();
      int zero_req;
      int inf_req;
      in_valid  = 1'b0;
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = (i != 5);
         signbit  = (i == 3 || i == 4);
         allzeros = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      zero_req = STATS ? 3 : 0;
      inf_req  = STATS ? 2 : 0;
      checks++;
      if (zero_count !== TB_CNT_W'(zero_req) || inf_count !== TB_CNT_W'(inf_req)) begin
         errors++;
         $display("[TB] FAIL counters zero=%0d inf=%0d expected %0d/%0d", zero_count, inf_count, zero_req, inf_req);
      end
      checks++;
      if (result_q !== 2'd2) begin
         errors++;
         $display("[TB] FAIL counters_hold result_q=%0d expected 2", result_q);
      end
   endtask

   task automatic test_saturation_clear();
      int zero_req;
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      in_valid  = 1'b1;
      signbit   = 1'b0;
      allzeros  = 1'b1;
      repeat (5) tick();
      zero_req = STATS ? CNT_MAX : 0;
      checks++;
      if (zero_count !== TB_CNT_W'(zero_req)) begin
         errors++;
         $display("[TB] FAIL saturate zero=%0d expected %0d", zero_count, zero_req);
      end
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      in_valid  = 1'b0;
      checks++;
      if (zero_count !== '0) begin
         errors++;
         $display("[TB] FAIL clear_wins zero=%0d expected 0", zero_count);
      end
   endtask

   task automatic test_random();
      logic [1:0] c;
      for (int n = 0; n < 300; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         signbit   = $urandom_range(0, 1);
         allzeros  = $urandom_range(0, 1);
         stats_clr = ($urandom_range(0, 15) == 0);
         c = ref_code(signbit, allzeros);
         #1;
         checks++;
         if (result !== c) begin
            errors++;
            $display("[TB] FAIL rand_comb n=%0d got=%0d expected=%0d", n, result, c);
         end
         tick();
         checks++;
         if (result_q !== exp_q || out_valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL rand_reg n=%0d got=%0d/%0b expected=%0d/%0b", n, result_q, out_valid, exp_q, exp_valid);
         end
         checks++;
         if (zero_count !== TB_CNT_W'(exp_zero) || inf_count !== TB_CNT_W'(exp_inf)) begin
            errors++;
            $display("[TB] FAIL rand_cnt n=%0d got=%0d/%0d expected=%0d/%0d", n, zero_count, inf_count, exp_zero, exp_inf);
         end
      end
      stats_clr = 1'b0;
      in_valid  = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_truth_table();
      test_hold();
      test_async_reset();
      test_counters();
      test_saturation_clear();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
